// File: rtl/starflux_pkg.sv
// Shared types and screen constants for the Starflux bullet pool.
package starflux_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sched_state_t;

    typedef enum logic {
        REQ_PLAYER = 1'b0,
        REQ_ENEMY  = 1'b1
    } req_t;

    localparam int SCREEN_ROWS = 120;
    localparam int SCREEN_COLS = 160;

endpackage

// File: rtl/bullet_tick_gen.sv
// Movement tick generator: down-counter reloading at terminal count,
// emitting a registered one-cycle tick every TICK_DIV clocks.
module bullet_tick_gen #(
    parameter int TICK_DIV = 833333
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count down to zero, pulse tick and reload on terminal count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= RELOAD;
            tick <= 1'b0;
        end else if (cnt == '0) begin
            cnt  <= RELOAD;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt - CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/bullet_scheduler.sv
// Bullet pool controller: arbitrates player/enemy fire requests into free
// slots and sweeps the pool on every movement tick.
// Optional macro BULLET_SCHED_COOLDOWN_EN: held player fire repeats every
// COOLDOWN ticks; without it, each press of player_fire fires once.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | serve one pending request per cycle, wait for tick
//   ST_SWEEP | advance slot idx by one row, SLOTS cycles in total
module bullet_scheduler
    import starflux_pkg::*;
#(
    parameter int SLOTS    = 8,
    parameter int X_W      = $clog2(SCREEN_COLS),
    parameter int Y_W      = 7,
    parameter int Y_MAX    = SCREEN_ROWS - 1,
    parameter int TICK_DIV = 833333,
    parameter int COOLDOWN = 15
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       player_fire,
    input  logic [X_W-1:0]             player_x,
    input  logic [Y_W-1:0]             player_y,
    input  logic                       enemy_fire,
    input  logic [X_W-1:0]             enemy_x,
    input  logic [Y_W-1:0]             enemy_y,
    input  logic                       hit_valid,
    input  logic [$clog2(SLOTS)-1:0]   hit_slot,
    output logic [SLOTS-1:0]           slot_active,
    output logic [SLOTS-1:0]           slot_up,
    output logic [SLOTS*X_W-1:0]       slot_x,
    output logic [SLOTS*Y_W-1:0]       slot_y,
    output logic                       tick,
    output logic                       grant_player,
    output logic                       grant_enemy,
    output logic                       drop
);

    localparam int IW = $clog2(SLOTS);

    generate
        if (SLOTS < 2 || (SLOTS & (SLOTS - 1)) != 0) begin : g_bad_slots
            $error("SLOTS must be a power of two and at least 2");
        end
        if (TICK_DIV < 2 * SLOTS) begin : g_bad_div
            $error("TICK_DIV must leave room for a full sweep");
        end
        if (COOLDOWN < 1) begin : g_bad_cooldown
            $error("COOLDOWN must be at least one tick");
        end
    endgenerate

    sched_state_t   state;
    logic [IW-1:0]  idx;
    logic [X_W-1:0] x_q [SLOTS];
    logic [Y_W-1:0] y_q [SLOTS];
    logic           player_pend;
    logic           enemy_pend;
    req_t           rr;
    logic           player_req;

    logic           has_free;
    logic [IW-1:0]  free_idx;
    logic           serve_player;
    logic           both_pend;

    bullet_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (tick)
    );

`ifdef BULLET_SCHED_COOLDOWN_EN
    localparam int CDW = $clog2(COOLDOWN + 1);
    logic [CDW-1:0] cooldown;

    assign player_req = player_fire && (cooldown == '0);

    // Refire cooldown: reload on each accepted request, drain once per tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cooldown <= '0;
        end else if (player_req) begin
            cooldown <= CDW'(COOLDOWN);
        end else if (tick && cooldown != '0) begin
            cooldown <= cooldown - CDW'(1);
        end
    end
`else
    logic fire_q;

    assign player_req = player_fire && !fire_q;

    // Edge register so a held trigger fires only once per press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fire_q <= 1'b0;
        end else begin
            fire_q <= player_fire;
        end
    end
`endif

    // Lowest-index free slot and requester choice, from registered state only.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
        both_pend    = player_pend && enemy_pend;
        serve_player = player_pend && (!enemy_pend || rr == REQ_PLAYER);
    end

    // Pool FSM: allocation in IDLE, one-slot-per-cycle movement in SWEEP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            slot_active  <= '0;
            slot_up      <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            player_pend  <= 1'b0;
            enemy_pend   <= 1'b0;
            rr           <= REQ_PLAYER;
            grant_player <= 1'b0;
            grant_enemy  <= 1'b0;
            drop         <= 1'b0;
        end else begin
            grant_player <= 1'b0;
            grant_enemy  <= 1'b0;
            drop         <= 1'b0;
            player_pend  <= player_pend || player_req;
            enemy_pend   <= enemy_pend || enemy_fire;

            // A hit on an already-free slot is harmless; allocation below overrides it.
            if (hit_valid) begin
                slot_active[hit_slot] <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state <= ST_SWEEP;
                        idx   <= '0;
                    end else if (player_pend || enemy_pend) begin
                        if (serve_player) begin
                            player_pend <= 1'b0;
                        end else begin
                            enemy_pend <= 1'b0;
                        end
                        if (both_pend) begin
                            rr <= (rr == REQ_PLAYER) ? REQ_ENEMY : REQ_PLAYER;
                        end
                        if (has_free) begin
                            slot_active[free_idx] <= 1'b1;
                            slot_up[free_idx]     <= serve_player;
                            x_q[free_idx]         <= serve_player ? player_x : enemy_x;
                            y_q[free_idx]         <= serve_player ? player_y : enemy_y;
                            grant_player          <= serve_player;
                            grant_enemy           <= !serve_player;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                end

                ST_SWEEP: begin
                    // A same-cycle hit on the swept slot retires it without moving.
                    if (slot_active[idx] && !(hit_valid && hit_slot == idx)) begin
                        if (slot_up[idx]) begin
                            if (y_q[idx] == '0) begin
                                slot_active[idx] <= 1'b0;
                            end else begin
                                y_q[idx] <= y_q[idx] - Y_W'(1);
                            end
                        end else begin
                            if (y_q[idx] == Y_W'(Y_MAX)) begin
                                slot_active[idx] <= 1'b0;
                            end else begin
                                y_q[idx] <= y_q[idx] + Y_W'(1);
                            end
                        end
                    end
                    if (idx == IW'(SLOTS - 1)) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Flatten slot coordinates for the collision checker and draw path.
    always_comb begin
        slot_x = '0;
        slot_y = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_x[i*X_W +: X_W] = x_q[i];
            slot_y[i*Y_W +: Y_W] = y_q[i];
        end
    end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Scoreboard bench for bullet_scheduler (SLOTS=4, TICK_DIV=16, COOLDOWN=2).
module tb_bullet_scheduler;

    localparam int SLOTS    = 4;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int Y_MAX    = 119;
    localparam int TICK_DIV = 16;
    localparam int COOLDOWN = 2;
    localparam int IW       = $clog2(SLOTS);

`ifdef BULLET_SCHED_COOLDOWN_EN
    localparam int HOLD_GRANTS = 5;
`else
    localparam int HOLD_GRANTS = 1;
`endif

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 player_fire = 1'b0;
    logic [X_W-1:0]       player_x = '0;
    logic [Y_W-1:0]       player_y = '0;
    logic                 enemy_fire = 1'b0;
    logic [X_W-1:0]       enemy_x = '0;
    logic [Y_W-1:0]       enemy_y = '0;
    logic                 hit_valid = 1'b0;
    logic [IW-1:0]        hit_slot = '0;
    logic [SLOTS-1:0]     slot_active;
    logic [SLOTS-1:0]     slot_up;
    logic [SLOTS*X_W-1:0] slot_x;
    logic [SLOTS*Y_W-1:0] slot_y;
    logic                 tick;
    logic                 grant_player;
    logic                 grant_enemy;
    logic                 drop;

    bullet_scheduler #(
        .SLOTS(SLOTS), .X_W(X_W), .Y_W(Y_W), .Y_MAX(Y_MAX),
        .TICK_DIV(TICK_DIV), .COOLDOWN(COOLDOWN)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .player_fire(player_fire), .player_x(player_x), .player_y(player_y),
        .enemy_fire(enemy_fire), .enemy_x(enemy_x), .enemy_y(enemy_y),
        .hit_valid(hit_valid), .hit_slot(hit_slot),
        .slot_active(slot_active), .slot_up(slot_up),
        .slot_x(slot_x), .slot_y(slot_y), .tick(tick),
        .grant_player(grant_player), .grant_enemy(grant_enemy), .drop(drop)
    );

    always #10 clock = ~clock;

    // kind: 0 = player grant, 1 = enemy grant, 2 = drop
    typedef struct {
        int kind;
        int slot;
        int x;
        int y;
        int up;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pgrants = 0;
    bit   mon_en = 1'b0;
    bit   chk_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int ys(input int i);
        return int'(slot_y[i*Y_W +: Y_W]);
    endfunction

    function automatic int xs(input int i);
        return int'(slot_x[i*X_W +: X_W]);
    endfunction

    task automatic push_exp(input int kind, input int slot, input int x, input int y, input int up);
        exp_t e;
        e.kind = kind; e.slot = slot; e.x = x; e.y = y; e.up = up;
        sbq.push_back(e);
    endtask

    // Monitor: every grant/drop pulse is checked against the next expectation.
    always @(negedge clock) begin
        int   k;
        exp_t e;
        if (mon_en && (grant_player || grant_enemy || drop)) begin
            if (grant_player) pgrants++;
            check("single_pulse", 32'(int'(grant_player) + int'(grant_enemy) + int'(drop)), 1);
            k = grant_player ? 0 : (grant_enemy ? 1 : 2);
            if (chk_en) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: got kind %0d, expected no pulse", k);
                end else begin
                    e = sbq.pop_front();
                    check("pulse_kind", k, e.kind);
                    if (e.kind != 2) begin
                        check("alloc_active", 32'(slot_active[e.slot]), 1);
                        check("alloc_up", 32'(slot_up[e.slot]), e.up);
                        check("alloc_x", xs(e.slot), e.x);
                        check("alloc_y", ys(e.slot), e.y);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 4 * TICK_DIV && !tick; i++) cyc(1);
        if (!tick) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_timeout: got no tick, expected one within %0d cycles", 4 * TICK_DIV);
        end
    endtask

    // Return in IDLE just after the sweep that follows each tick.
    task automatic after_ticks(input int n);
        repeat (n) begin
            wait_tick();
            cyc(SLOTS + 1);
        end
    endtask

    task automatic enemy_shot(input int x, input int y);
        enemy_x = X_W'(x);
        enemy_y = Y_W'(y);
        enemy_fire = 1'b1;
        cyc(1);
        enemy_fire = 1'b0;
    endtask

    task automatic clear_all();
        for (int s = 0; s < SLOTS; s++) begin
            hit_valid = 1'b1;
            hit_slot = IW'(s);
            cyc(1);
        end
        hit_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected completion within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        reset_n = 1'b1;
        check("reset_ctrl", {22'd0, slot_active, slot_up, grant_player, grant_enemy}, 0);
        check("reset_pulse", {30'd0, drop, tick}, 0);
        check("reset_xy", 32'(slot_x == '0 && slot_y == '0), 1);
        mon_en = 1'b1;

        // Enemy shot straight after reset, two-cycle grant latency, then 4 moves.
        push_exp(1, 0, 40, 10, 0);
        enemy_shot(40, 10);
        check("no_early_grant", 32'(grant_enemy), 0);
        cyc(1);
        check("enemy_latency", 32'(grant_enemy), 1);
        after_ticks(4);
        check("enemy_move_active", 32'(slot_active[0]), 1);
        check("enemy_move_y", ys(0), 14);
        clear_all();

        // Simultaneous requests: round-robin rotates between the two rounds.
        after_ticks(3);
        push_exp(0, 0, 20, 50, 1);
        push_exp(1, 1, 60, 30, 0);
        player_x = 8'd20; player_y = 7'd50; enemy_x = 8'd60; enemy_y = 7'd30;
        player_fire = 1'b1; enemy_fire = 1'b1;
        cyc(1);
        player_fire = 1'b0; enemy_fire = 1'b0;
        cyc(4);
        check("arb1_active", 32'(slot_active), 32'h3);
        clear_all();
        after_ticks(3);
        push_exp(1, 0, 61, 31, 0);
        push_exp(0, 1, 21, 51, 1);
        player_x = 8'd21; player_y = 7'd51; enemy_x = 8'd61; enemy_y = 7'd31;
        player_fire = 1'b1; enemy_fire = 1'b1;
        cyc(1);
        player_fire = 1'b0; enemy_fire = 1'b0;
        cyc(4);
        check("arb2_active", 32'(slot_active), 32'h3);
        clear_all();

        // Pool full: four live slots, fifth request dropped and not retried.
        after_ticks(1);
        for (int i = 0; i < SLOTS; i++) begin
            push_exp(1, i, i + 1, i + 5, 0);
            enemy_shot(i + 1, i + 5);
            cyc(1);
        end
        after_ticks(1);
        check("full_active", 32'(slot_active), 32'hF);
        push_exp(2, 0, 0, 0, 0);
        enemy_shot(99, 9);
        cyc(2);
        check("drop_active", 32'(slot_active), 32'hF);
        check("drop_x", slot_x, 32'h04030201);
        hit_valid = 1'b1; hit_slot = 2'd3;
        cyc(1);
        hit_valid = 1'b0;
        cyc(6);
        check("drop_pend_cleared", 32'(slot_active), 32'h7);
        clear_all();

        // Screen-edge retire, upward then downward.
        after_ticks(3);
        push_exp(0, 0, 10, 2, 1);
        player_x = 8'd10; player_y = 7'd2; player_fire = 1'b1;
        cyc(3);
        player_fire = 1'b0;
        after_ticks(1);
        check("up_t1", {31'd0, slot_active[0]}, 1);
        check("up_t1_y", ys(0), 1);
        after_ticks(1);
        check("up_t2", {31'd0, slot_active[0]}, 1);
        check("up_t2_y", ys(0), 0);
        after_ticks(1);
        check("up_t3_retired", {31'd0, slot_active[0]}, 0);
        push_exp(1, 0, 9, 118, 0);
        enemy_shot(9, 118);
        cyc(2);
        after_ticks(1);
        check("down_t1", {31'd0, slot_active[0]}, 1);
        check("down_t1_y", ys(0), Y_MAX);
        after_ticks(1);
        check("down_t2_retired", {31'd0, slot_active[0]}, 0);

        // Hit on the slot under sweep; request raised mid-sweep reuses it.
        after_ticks(1);
        for (int i = 0; i < SLOTS; i++) begin
            push_exp(1, i, 30 + i, 20, 0);
            enemy_shot(30 + i, 20);
            cyc(1);
        end
        wait_tick();
        cyc(2);
        push_exp(1, 2, 77, 40, 0);
        enemy_x = 8'd77; enemy_y = 7'd40; enemy_fire = 1'b1;
        cyc(1);
        enemy_fire = 1'b0;
        hit_valid = 1'b1; hit_slot = 2'd2;
        cyc(1);
        hit_valid = 1'b0;
        cyc(1);
        check("sweep_hit_active", 32'(slot_active), 32'hB);
        check("sweep_hit_y2", ys(2), 20);
        check("sweep_move_y0", ys(0), 21);
        check("sweep_move_y3", ys(3), 21);
        cyc(2);
        check("sweep_realloc", 32'(slot_active), 32'hF);
        clear_all();

        // Held player fire across about ten ticks.
        after_ticks(3);
        chk_en = 1'b0;
        pgrants = 0;
        wait_tick();
        player_x = 8'd5; player_y = 7'd1; player_fire = 1'b1;
        cyc(9 * TICK_DIV + 8);
        player_fire = 1'b0;
        cyc(40);
        chk_en = 1'b1;
        check("held_fire_grants", pgrants, HOLD_GRANTS);
        clear_all();

        // Asynchronous reset in the middle of a sweep.
        after_ticks(1);
        push_exp(1, 0, 50, 50, 0);
        enemy_shot(50, 50);
        cyc(2);
        wait_tick();
        cyc(2);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_slots", 32'(slot_active), 0);
        cyc(2);
        reset_n = 1'b1;
        push_exp(1, 0, 3, 3, 0);
        enemy_shot(3, 3);
        cyc(1);
        check("post_reset_grant", 32'(grant_enemy), 1);

        for (int i = 0; i < 50 && sbq.size() != 0; i++) cyc(1);
        check("scoreboard_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bullet_scheduler.md
# bullet_scheduler

Bullet pool controller for Starflux. It owns a fixed pool of bullet slots and arbitrates fire requests from the player and the enemy into free slots. On each movement tick it sweeps the pool to advance every live bullet one row: player bullets move up, enemy bullets move down. Slots are retired at the screen edge or on a collision report. Its slot vectors feed the collision checker and the VGA draw path.

## Interface
Parameters:
- SLOTS, 8: number of bullet slots (≥2, power of 2)
- X_W, 8: column coordinate width
- Y_W, 7: row coordinate width
- Y_MAX, 119: bottom screen row
- TICK_DIV, 833333: clocks per movement tick (≥ 2*SLOTS)
- COOLDOWN, 15: player refire interval, in ticks

Ports:
- clock  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- player_fire  in  1  level, fire held
- player_x / player_y  in  X_W / Y_W  player ship position
- enemy_fire  in  1  single-cycle fire request
- enemy_x / enemy_y  in  X_W / Y_W  enemy ship position
- hit_valid  in  1  collision retire strobe
- hit_slot  in  $clog2(SLOTS)  slot to retire
- slot_active  out  SLOTS  slot live
- slot_up  out  SLOTS  1 = player bullet (moves up)
- slot_x  out  SLOTS*X_W  packed column, slot i at [i*X_W +: X_W]
- slot_y  out  SLOTS*Y_W  packed row
- tick  out  1  one-cycle movement tick
- grant_player / grant_enemy  out  1  one-cycle pulse, slot allocated
- drop  out  1  one-cycle pulse, request discarded because the pool is full

## Operation
- Tick counter loads TICK_DIV-1 and counts down. At 0 it pulses tick and reloads.
- Enemy request:
  - enemy_fire=1 sets enemy_pend.
  - A second pulse while pending is merged.
- Player request (see Configuration): sets player_pend.
- FSM states are IDLE and SWEEP.
- IDLE:
  - If tick is high, go to SWEEP with idx=0. Allocation is deferred; pending bits are held.
  - Otherwise, if any pend bit is set, service one request this cycle:
    - Requester choice: if both are pending, serve the rr priority holder; rr then passes to the other requester. The loser stays pending and is served in the next IDLE cycle.
    - Slot choice: lowest-index inactive slot.
    - Slot load: active=1, up=1 for player or 0 for enemy, x/y = the requester's position sampled this cycle.
    - Completion: the matching grant_* pulses and the served pend bit clears.
  - No free slot: drop pulses, the served pend bit clears, and rr still rotates.
- SWEEP, one slot per cycle at slot idx:
  - Inactive slot: no change.
  - up=1: if y==0, retire the slot; else y-1.
  - up=0: if y==Y_MAX, retire the slot; else y+1.
  - idx increments. After idx==SLOTS-1, return to IDLE.
- hit_valid:
  - Clears slot_active[hit_slot] in any state or cycle.
  - If it targets the slot being swept, retire wins and no move is applied.
  - If the slot is inactive, it is ignored.
- The free vector comes from registered state. A slot freed this cycle is allocatable the next cycle.

## Timing
- Reset values:
  - all outputs 0
  - slot_x/slot_y 0
  - state IDLE, idx 0
  - tick counter TICK_DIV-1
  - pend bits 0, rr = player
  - cooldown 0, edge register 0
- Request latency:
  - Request sampled in cycle n, pend set at the n+1 edge.
  - Grant or drop asserted in cycle n+1 with the slot visible in n+2, provided the FSM is in IDLE and tick=0.
- A sweep occupies exactly SLOTS cycles after the tick cycle. Requests arriving during a sweep wait.
- grant_*, drop and tick are registered single-cycle pulses and are never asserted in SWEEP.
- An asynchronous reset mid-sweep abandons the sweep and clears every slot.

## Configuration
- BULLET_SCHED_COOLDOWN_EN defined:
  - While player_fire=1 and cooldown==0, set player_pend and load cooldown with COOLDOWN.
  - cooldown decrements on each tick.
  - Holding fire produces one request per COOLDOWN ticks.
- Undefined:
  - Rising-edge detect on player_fire gives one request per press.
  - The cooldown counter is absent.

## Structure
- starflux_pkg:
  - FSM state enum
  - requester enum (REQ_PLAYER, REQ_ENEMY)
  - SCREEN_ROWS / SCREEN_COLS constants
- Sub-module bullet_tick_gen (TICK_DIV counter, tick pulse), instantiated once.
- Slot arrays, arbiter and FSM stay in bullet_scheduler.

## Test plan
Bench setting: SLOTS=4, TICK_DIV=16, Y_MAX=119, COOLDOWN=2.
- Reset check: after reset, enemy_fire pulse at (40,10) -> grant_enemy 2 cycles later; slot0 active, up=0, x=40, y=10. Four ticks later, y=14.
- Arbitration: player and enemy pending in the same IDLE cycle -> player granted slot0, then enemy granted slot1 the next cycle. Repeating the scenario grants enemy first (rr rotated).
- Pool full: 4 slots live, then enemy_fire -> drop pulse, no grant, slot state unchanged, enemy_pend clear.
- Edge retire: player bullet spawned at y=2 -> slot0 active for 2 ticks (y=1, then y=0), retired on the 3rd tick. Enemy bullet at y=118 -> retired on the 2nd tick.
- Hit during sweep: hit_valid with hit_slot=2 in the sweep cycle for idx=2 -> slot2 inactive, y unchanged. A pending request then allocates slot2.
- Cooldown (with COOLDOWN_EN): player_fire held high for 10 ticks -> exactly 5 grant_player pulses. Without the macro, the same stimulus gives 1 pulse.
